// File: rtl/sr_command_sequencer.sv
// Command sequencer driving a JK-based SR flip-flop: set/reset/toggle commands become timed S/R pulses with a guard gap and q-feedback check.
// Optional build macro SR_SEQ_SKIP_REDUNDANT_EN: a set while exp_q==1 or a reset while exp_q==0 is consumed without a pulse.
module sr_command_sequencer #(
  parameter int PULSE_W = 1,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  output logic       exp_q,
  output logic       busy,
  output logic       err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               want_set;
  logic               want_pulse;

  // Handshake: a command transfers on a rising edge where req_valid && req_ready;
  // req_op is sampled only on that edge, and ready is low whenever a command is in flight.
  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Toggle resolves against the pre-update exp_q.
  always_comb begin
    want_set   = 1'b0;
    want_pulse = 1'b0;
    case (req_op)
      2'b01: begin want_set = 1'b1;   want_pulse = 1'b1; end
      2'b10: begin want_set = 1'b0;   want_pulse = 1'b1; end
      2'b11: begin want_set = !exp_q; want_pulse = 1'b1; end
      default: ;
    endcase
`ifdef SR_SEQ_SKIP_REDUNDANT_EN
    if ((req_op == 2'b01) && exp_q)  want_pulse = 1'b0;
    if ((req_op == 2'b10) && !exp_q) want_pulse = 1'b0;
`else
`endif
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      s     <= 1'b0;
      r     <= 1'b0;
      exp_q <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && want_pulse) begin
            s     <= want_set;
            r     <= !want_set;
            exp_q <= want_set;
            cnt   <= CNT_W'(PULSE_W - 1);
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            s <= 1'b0;
            r <= 1'b0;
            if (GAP_W > 0) begin
              cnt   <= CNT_W'(GAP_W - 1);
              state <= GAP;
            end else begin
              state <= CHECK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= CHECK;
          else           cnt   <= cnt - 1'b1;
        end
        CHECK: begin
          if (q_fb != exp_q) err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sr_command_sequencer.md
Name: sr_command_sequencer

Overview:
Upstream driver stage for the JK-based SR flip-flop. It accepts set/reset/toggle commands over a valid/ready handshake and turns each into a timed S or R pulse. S and R are never asserted together, and an idle guard gap follows every pulse. It tracks the expected flip-flop state and checks it against the q feedback, flagging any mismatch in a sticky error bit.

Parameters:
PULSE_W, 1, cycles S or R is held high per command; legal range 1..15.
GAP_W, 1, idle cycles with S=R=0 after each pulse; legal range 0..15.
CNT_W, 4, width of the internal pulse/gap counter; must hold max(PULSE_W, GAP_W).

Ports:
clock  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  command present.
req_op  in  2  00 no-op, 01 set, 10 reset, 11 toggle.
req_ready  out  1  block can accept a command this cycle.
s  out  1  set drive to the flip-flop; registered.
r  out  1  reset drive to the flip-flop; registered.
q_fb  in  1  q returned from the flip-flop.
exp_q  out  1  expected flip-flop state; registered.
busy  out  1  high in every state except IDLE.
err  out  1  sticky mismatch flag; registered.

Behaviour:
- Reset and clocking: one clock (clock); reset rst is synchronous and active-high. While rst=1 at an edge: state=IDLE, s=0, r=0, exp_q=0, err=0, counter=0. Any in-flight command is dropped.
- req_ready is combinational: (state==IDLE) && !rst. busy = (state!=IDLE).
- A command is accepted at an edge where req_valid && req_ready.
- FSM states: IDLE, DRIVE, GAP, CHECK.
- IDLE on accept:
  - op 00: consumed, no pulse, stays IDLE, exp_q unchanged.
  - op 01: s=1 next cycle, exp_q<=1, go to DRIVE.
  - op 10: r=1 next cycle, exp_q<=0, go to DRIVE.
  - op 11: if exp_q==0, act as set; else act as reset. Decision uses the pre-update exp_q.
- DRIVE: the selected line stays high exactly PULSE_W cycles. On the last cycle, s and r are cleared at the next edge. Go to GAP if GAP_W>0, else to CHECK.
- GAP: s=r=0 for exactly GAP_W cycles, then CHECK.
- CHECK: one cycle. If q_fb != exp_q, err<=1. Then IDLE.
- Latency: accept at edge N; pulse occupies cycles N+1..N+PULSE_W; busy spans PULSE_W+GAP_W+1 cycles. The next accept is possible at the first edge after CHECK.
- Invariants:
  - s&r==0 on every cycle.
  - s and r are never high outside DRIVE.
  - err is cleared only by rst.
- req_op is sampled only at acceptance; changes while busy are ignored.
- rst mid-DRIVE: s/r drop at that same edge, and no CHECK is performed.

Optional Feature:
SR_SEQ_SKIP_REDUNDANT_EN
- Defined: a set with exp_q==1 or a reset with exp_q==0 is consumed like op 00. No pulse is issued, no CHECK is performed, and the block stays IDLE. Toggle is unaffected.
- Not defined: every set/reset command issues a full pulse/gap/check sequence regardless of exp_q.

Test Plan:
- Reset (PULSE_W=1, GAP_W=1): rst=1 for 1 cycle -> s=r=0, exp_q=0, err=0, req_ready=1 on the cycle after rst drops.
- Set then reset (PULSE_W=2, GAP_W=1), q_fb wired to a correct SR flip-flop model -> s high exactly 2 cycles after accept; busy for 4 cycles; exp_q=1; then r high 2 cycles; exp_q=0; err stays 0.
- Toggle x3 from reset -> pulse pattern s, r, s; final exp_q=1; s&r never 1 on any cycle.
- Mismatch: set command with q_fb tied 0 -> err=1 in the cycle after CHECK. err stays 1 through later correct commands until rst.
- Mid-operation reset: rst asserted in the 2nd DRIVE cycle (PULSE_W=3) -> s=0 at that edge, exp_q=0, err=0, req_ready=1 next cycle.
- Redundant set with exp_q=1:
  - With SR_SEQ_SKIP_REDUNDANT_EN defined: no s pulse, busy stays 0.
  - Without it: s pulses PULSE_W cycles.
